bk8_bist_checker: RTL

- Synthesizable built-in self-test engine for the 8-bit Brent-Kung adder in the MAC datapath.
- Generates the operand stimulus and checks the adder's response in hardware: drives a/b/cin into the adder, samples s/cout, and compares against an internal behavioural golden sum.
- Reports error count, first failing vector and pass/fail through a start/done handshake.
- Used for silicon/FPGA self-test of adder instances inside the MAC unit.

---
 rtl/bk8_bist_checker.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bk8_bist_checker.sv
// bk8_bist_checker: built-in self-test engine for the 8-bit Brent-Kung adder
//   clk, rst_n (sync, active-low); start: run request, honoured in IDLE/DONE
//   a_o/b_o/cin_o: operands to adder; s_i/cout_i: adder response
//   busy/done/pass: run status; err_count: saturating error count
//   first_fail_idx: first failing vector index, 16'hFFFF when none
module bk8_bist_checker #(
  parameter int          NUM_VECTORS = 256,
  parameter int          LATENCY     = 0,
  parameter logic [16:0] SEED        = 17'h1ACE5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  a_o,
  output logic [7:0]  b_o,
  output logic        cin_o,
  input  logic [7:0]  s_i,
  input  logic        cout_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_fail_idx
);
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
  state_t      state_q, state_d;
  logic [16:0] lfsr_q, lfsr_d;
  logic [15:0] idx_q, idx_d, wcnt_q, wcnt_d, err_q, err_d, ffi_q, ffi_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        cin_q, cin_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [8:0]  gold;
  logic [16:0] vec;
  logic        mism;
  assign gold = {1'b0, a_q} + {1'b0, b_q} + {8'b0, cin_q};
  assign mism = {cout_i, s_i} != gold;
  // first four vectors are fixed carry-chain corner cases, the rest come from the LFSR
  assign vec = idx_q == 16'd0 ? {8'hFF, 8'h01, 1'b0} :
               idx_q == 16'd1 ? {8'h00, 8'h00, 1'b1} :
               idx_q == 16'd2 ? {8'hA5, 8'h5A, 1'b1} :
               idx_q == 16'd3 ? {8'hF0, 8'h0F, 1'b1} : lfsr_q;
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        // the first cycle in DONE still has busy set: publish results, ignore start
        if (state_q == DONE && busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = err_q == 16'd0;
        end else if (start) begin
          state_d = DRIVE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = 16'd0;
          ffi_d   = 16'hFFFF;
          lfsr_d  = SEED;
          idx_d   = 16'd0;
        end
      end
      DRIVE: begin
        {a_d, b_d, cin_d} = vec;
        lfsr_d  = idx_q >= 16'd4 ? {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]} : lfsr_q;
        wcnt_d  = 16'd0;
        state_d = LATENCY == 0 ? CHECK : WAIT;
      end
      WAIT: begin
        wcnt_d  = wcnt_q + 16'd1;
        state_d = int'(wcnt_q) + 1 >= LATENCY ? CHECK : WAIT;
      end
      CHECK: begin
        err_d   = mism && err_q != 16'hFFFF ? err_q + 16'd1 : err_q;
        ffi_d   = mism && ffi_q == 16'hFFFF ? idx_q : ffi_q;
        idx_d   = idx_q + 16'd1;
        state_d = idx_q == 16'(NUM_VECTORS - 1) ? DONE : DRIVE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      idx_q   <= 16'd0;
      wcnt_q  <= 16'd0;
      err_q   <= 16'd0;
      ffi_q   <= 16'hFFFF;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      cin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end
  assign a_o            = a_q;
  assign b_o            = b_q;
  assign cin_o          = cin_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;
endmodule
